// File: rtl/math_seq.sv
// ---------------------------------------------------------------------------
// math_seq -- command sequencer for a byte-serial math engine.
//
// Converts whole-word commands into per-cycle opcode/operand pairs for a
// registered math engine, which has two BITS-wide accumulators and returns
// the low byte of accum0.
//   LOAD0 : writes cmd_data into accum0 one byte at a time, MSB first.
//   READ0 : copies accum0 into accum1, reads it back byte by byte through
//           shifts, then restores accum0 from the copy.
//   RAW   : passes one opcode/operand pair straight through, except that
//           op 01 (output select) is replaced by NOP.
//   kind 3: reserved; accepted and issued as a NOP.
//
// Ports
//   clk, rst_n         clock; asynchronous active-low reset
//   cmd_valid/ready    command handshake (ready only in IDLE)
//   cmd_kind [1:0]     0=LOAD0 1=READ0 2=RAW 3=reserved
//   cmd_data [BITS]    LOAD0 value; for RAW [15:8]=op, [7:0]=data
//   rsp_valid/ready    READ0 result handshake
//   rsp_data [BITS]    READ0 result, held until the next READ0 overwrites it
//   m_op, m_data [8]   registered opcode/operand to the math engine
//   m_result [8]       engine low-byte result, one cycle behind m_op
//   busy               high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module math_seq #(
    parameter int BITS = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_kind,
    input  logic [BITS-1:0] cmd_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [BITS-1:0] rsp_data,
    output logic [7:0]      m_op,
    output logic [7:0]      m_data,
    input  logic [7:0]      m_result,
    output logic            busy
);

    localparam int unsigned NB = BITS / 8;
    localparam int unsigned CW = $clog2(NB) + 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_SEL   = 8'h01;
    localparam logic [7:0] OP_CLR1  = 8'h03;
    localparam logic [7:0] OP_LDLO  = 8'h04;
    localparam logic [7:0] OP_ADD   = 8'h09;
    localparam logic [7:0] OP_SHL0  = 8'h0A;
    localparam logic [7:0] OP_SHR1  = 8'h0D;

    typedef enum logic [1:0] {IDLE, LOAD, READ, WAIT_RSP} state_t;
    typedef enum logic [1:0] {RD_ADD, RD_SHIFT, RD_RESTORE, RD_DRAIN} rd_step_t;

    state_t          state, state_n;
    rd_step_t        rd_step, rd_step_n;
    logic [CW-1:0]   bcnt, bcnt_n;     // LOAD: bytes still to load; READ: shift index
    logic [CW-1:0]   cap_cnt;          // next rsp_data byte to capture
    logic            sh_next, sh_next_n;
    logic [BITS-1:0] ld_sr, ld_sr_n;   // remaining LOAD0 bytes, next one at the top
    logic [1:0]      pend;             // tracks shift ops through the engine latency
    logic            shift_issue;
    logic            last_capture;
    logic            rsp_valid_n;
    logic [7:0]      op_n, data_n;
    logic [15:0]     raw_word;
    logic            accept;

    assign cmd_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign accept       = cmd_valid && cmd_ready;
    assign raw_word     = 16'(cmd_data);
    assign last_capture = pend[1] && (cap_cnt == LAST);

    always_comb begin
        state_n     = state;
        rd_step_n   = rd_step;
        bcnt_n      = bcnt;
        sh_next_n   = sh_next;
        ld_sr_n     = ld_sr;
        shift_issue = 1'b0;
        rsp_valid_n = rsp_valid;
        op_n        = OP_NOP;
        data_n      = 8'h00;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (cmd_kind)
                        2'd0: begin
                            op_n      = OP_LDLO;
                            data_n    = cmd_data[BITS-1 -: 8];
                            ld_sr_n   = cmd_data << 8;
                            bcnt_n    = LAST;
                            sh_next_n = 1'b1;
                            state_n   = LOAD;
                        end
                        2'd1: begin
                            op_n      = OP_CLR1;
                            bcnt_n    = '0;
                            rd_step_n = RD_ADD;
                            state_n   = READ;
                        end
                        2'd2: begin
                            op_n    = (raw_word[15:8] == OP_SEL) ? OP_NOP : raw_word[15:8];
                            data_n  = raw_word[7:0];
                            bcnt_n  = '0;
                            state_n = LOAD;
                        end
                        default: begin
                            bcnt_n  = '0;
                            state_n = LOAD;
                        end
                    endcase
                end
            end

            // Single-op commands (RAW, reserved) also pass through LOAD with
            // nothing left to load, so they return to IDLE one edge later.
            LOAD: begin
                if (bcnt == '0) begin
                    state_n = IDLE;
                end else if (sh_next) begin
                    op_n      = OP_SHL0;
                    data_n    = 8'h08;
                    sh_next_n = 1'b0;
                end else begin
                    op_n      = OP_LDLO;
                    data_n    = ld_sr[BITS-1 -: 8];
                    ld_sr_n   = ld_sr << 8;
                    bcnt_n    = bcnt - 1'b1;
                    sh_next_n = 1'b1;
                end
            end

            READ: begin
                unique case (rd_step)
                    RD_ADD: begin
                        op_n      = OP_ADD;
                        rd_step_n = RD_SHIFT;
                    end
                    RD_SHIFT: begin
                        op_n        = OP_SHR1;
                        data_n      = 8'({bcnt, 3'b000});
                        shift_issue = 1'b1;
                        bcnt_n      = bcnt + 1'b1;
                        if (bcnt == LAST) begin
                            rd_step_n = RD_RESTORE;
                        end
                    end
                    RD_RESTORE: begin
                        op_n      = OP_SHR1;
                        rd_step_n = RD_DRAIN;
                    end
                    default: begin
                        // The last byte lands on the same edge that raises rsp_valid.
                        if (last_capture) begin
                            state_n     = WAIT_RSP;
                            rsp_valid_n = 1'b1;
                        end
                    end
                endcase
            end

            default: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_step   <= RD_ADD;
            bcnt      <= '0;
            cap_cnt   <= '0;
            sh_next   <= 1'b0;
            ld_sr     <= '0;
            pend      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            m_op      <= OP_NOP;
            m_data    <= 8'h00;
        end else begin
            state     <= state_n;
            rd_step   <= rd_step_n;
            bcnt      <= bcnt_n;
            sh_next   <= sh_next_n;
            ld_sr     <= ld_sr_n;
            pend      <= {pend[0], shift_issue};
            rsp_valid <= rsp_valid_n;
            m_op      <= op_n;
            m_data    <= data_n;
            // A shift issued at edge n shows its byte on m_result after edge
            // n+1, so it is captured at edge n+2.
            if (pend[1]) begin
                cap_cnt <= (cap_cnt == LAST) ? '0 : cap_cnt + 1'b1;
                for (int unsigned i = 0; i < NB; i++) begin
                    if (cap_cnt == CW'(i)) begin
                        rsp_data[8*i +: 8] <= m_result;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_math_seq.sv
module tb_math_seq;

    localparam int BITS = 64;
    localparam int NB   = BITS / 8;
    typedef logic [BITS-1:0] word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_kind = 2'd0;
    word_t       cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    word_t       rsp_data;
    logic [7:0]  m_op, m_data, m_result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    math_seq #(.BITS(BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_kind  (cmd_kind),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .m_op      (m_op),
        .m_data    (m_data),
        .m_result  (m_result),
        .busy      (busy)
    );

    // Behavioural math engine: registered, shares rst_n, output select fixed at accum0.
    word_t acc0, acc1;
    logic  op01_seen = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc0 <= '0;
            acc1 <= '0;
        end else begin
            case (m_op)
                8'h03: acc1 <= '0;
                8'h04: acc0[7:0] <= m_data;
                8'h09: acc1 <= acc0 + acc1;
                8'h0A: acc0 <= acc0 << m_data;
                8'h0D: acc0 <= acc1 >> m_data;
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (m_op == 8'h01) op01_seen <= 1'b1;
    end

    assign m_result = acc0[7:0];

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected op stream for a command, straight from the command definitions.
    logic [15:0] exp_q[$];

    task automatic build_ops(input logic [1:0] kind, input word_t data);
        logic [7:0] op;
        exp_q.delete();
        case (kind)
            2'd0: begin
                for (int i = NB - 1; i >= 0; i--) begin
                    exp_q.push_back({8'h04, data[8*i +: 8]});
                    if (i > 0) exp_q.push_back(16'h0A08);
                end
            end
            2'd1: begin
                exp_q.push_back(16'h0300);
                exp_q.push_back(16'h0900);
                for (int k = 0; k < NB; k++) exp_q.push_back({8'h0D, 8'((8 * k) % 256)});
                exp_q.push_back(16'h0D00);
            end
            2'd2: begin
                op = data[15:8];
                if (op == 8'h01) op = 8'h00;
                exp_q.push_back({op, data[7:0]});
            end
            default: exp_q.push_back(16'h0000);
        endcase
    endtask

    // Issue one command, check every op edge, the return to IDLE and, for
    // READ0, the response handshake with 'hold' cycles of rsp_ready low.
    task automatic do_cmd(input logic [1:0] kind, input word_t data, input word_t exp_rsp,
                          input int hold, input string tag);
        logic rdy;
        bit   acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_kind  = kind;
        cmd_data  = data;
        for (int n = 0; n < 20; n++) begin
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                acc = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL %s accept: got no acceptance expected acceptance within 20 cycles", tag);
            return;
        end
        foreach (exp_q[i]) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            chk({tag, " op"}, word_t'({m_op, m_data}), word_t'(exp_q[i]));
            if (i == 0) chk({tag, " busy"}, word_t'(busy), word_t'(1'b1));
        end
        @(posedge clk);
        #1;
        chk({tag, " op_after"}, word_t'({m_op, m_data}), word_t'(16'h0000));
        if (kind == 2'd1) begin
            chk({tag, " rsp_valid_rise"}, word_t'(rsp_valid), word_t'(1'b1));
            chk({tag, " rsp_data"}, rsp_data, exp_rsp);
            chk({tag, " ready_in_wait"}, word_t'(cmd_ready), word_t'(1'b0));
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                chk({tag, " hold_valid"}, word_t'(rsp_valid), word_t'(1'b1));
                chk({tag, " hold_data"}, rsp_data, exp_rsp);
                chk({tag, " hold_ready"}, word_t'(cmd_ready), word_t'(1'b0));
                chk({tag, " hold_op"}, word_t'(m_op), word_t'(8'h00));
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            chk({tag, " rsp_valid_drop"}, word_t'(rsp_valid), word_t'(1'b0));
            chk({tag, " ready_after_rsp"}, word_t'(cmd_ready), word_t'(1'b1));
            chk({tag, " rsp_data_held"}, rsp_data, exp_rsp);
        end else begin
            chk({tag, " ready_after"}, word_t'(cmd_ready), word_t'(1'b1));
            chk({tag, " busy_after"}, word_t'(busy), word_t'(1'b0));
        end
    endtask

    typedef struct {
        logic [1:0]  kind;
        word_t       data;
        logic [15:0] op_word;
    } vec_t;

    vec_t  tbl[7];
    word_t ref_val;
    word_t snap;
    int    accepts;
    logic  rdy;

    initial begin
        tbl[0] = '{2'd2, 64'h0000_0000_0000_0605, 16'h0605};
        tbl[1] = '{2'd2, 64'h0000_0000_0000_01FF, 16'h00FF};
        tbl[2] = '{2'd2, 64'hFFFF_FFFF_FFFF_0A80, 16'h0A80};
        tbl[3] = '{2'd2, 64'h0000_0000_0000_0000, 16'h0000};
        tbl[4] = '{2'd3, 64'hDEAD_BEEF_0000_0605, 16'h0000};
        tbl[5] = '{2'd2, 64'h1234_0000_0000_FF01, 16'hFF01};
        tbl[6] = '{2'd2, 64'h0000_0000_0000_0103, 16'h0003};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst m_op", word_t'(m_op), word_t'(8'h00));
        chk("rst m_data", word_t'(m_data), word_t'(8'h00));
        chk("rst rsp_valid", word_t'(rsp_valid), word_t'(1'b0));
        chk("rst rsp_data", rsp_data, '0);
        chk("rst busy", word_t'(busy), word_t'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst cmd_ready", word_t'(cmd_ready), word_t'(1'b1));
        chk("post_rst m_op", word_t'({m_op, m_data}), word_t'(16'h0000));

        // Table-driven single-op commands
        for (int i = 0; i < 7; i++) begin
            exp_q.delete();
            exp_q.push_back(tbl[i].op_word);
            do_cmd(tbl[i].kind, tbl[i].data, '0, 0, $sformatf("tbl%0d", i));
        end

        // LOAD0 of the reference word, RAW straight after, then READ0 with a held response
        ref_val = 64'h0123_4567_89AB_CDEF;
        build_ops(2'd0, ref_val);
        chk("load first op", word_t'(exp_q[0]), word_t'(16'h0401));
        do_cmd(2'd0, ref_val, '0, 0, "load_ref");
        chk("load acc0", acc0, ref_val);
        exp_q.delete();
        exp_q.push_back(16'h0605);
        do_cmd(2'd2, 64'h0605, '0, 0, "raw_b2b");
        build_ops(2'd1, '0);
        do_cmd(2'd1, '0, ref_val, 5, "read_ref");
        chk("read acc0 low", word_t'(acc0[7:0]), word_t'(8'hEF));
        chk("read acc0", acc0, ref_val);
        chk("read acc1 copy", acc1, ref_val);

        // Reset in the middle of a LOAD0
        cmd_valid = 1'b1;
        cmd_kind  = 2'd0;
        cmd_data  = 64'hFEDC_BA98_7654_3210;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("mid_rst first op", word_t'({m_op, m_data}), word_t'(16'h04FE));
        repeat (6) @(posedge clk);
        #1;
        chk("mid_rst busy_before", word_t'(busy), word_t'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst m_op", word_t'(m_op), word_t'(8'h00));
        chk("mid_rst busy", word_t'(busy), word_t'(1'b0));
        chk("mid_rst rsp_valid", word_t'(rsp_valid), word_t'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("post_abort op", word_t'({m_op, m_data}), word_t'(16'h0000));
            chk("post_abort ready", word_t'(cmd_ready), word_t'(1'b1));
        end

        // Reserved kind with cmd_valid held: one acceptance every two cycles
        accepts   = 0;
        cmd_valid = 1'b1;
        cmd_kind  = 2'd3;
        cmd_data  = 64'h0000_0000_0000_0605;
        for (int c = 0; c < 8; c++) begin
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) accepts++;
            chk("kind3 m_op", word_t'(m_op), word_t'(8'h00));
        end
        cmd_valid = 1'b0;
        chk("kind3 accepts", word_t'(accepts), word_t'(4));
        @(posedge clk);
        #1;

        // Random commands against the engine model
        for (int r = 0; r < 40; r++) begin
            logic [1:0] kind;
            word_t      data;
            int         hold;
            kind = 2'($urandom_range(0, 3));
            data = {$urandom, $urandom};
            hold = $urandom_range(0, 3);
            build_ops(kind, data);
            snap = acc0;
            do_cmd(kind, data, snap, hold, $sformatf("rnd%0d", r));
            if (kind == 2'd0) chk("rnd load acc0", acc0, data);
            if (kind == 2'd1) begin
                chk("rnd read acc0", acc0, snap);
                chk("rnd read acc1", acc1, snap);
            end
        end

        chk("no op01 issued", word_t'(op01_seen), word_t'(1'b0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
